// File: rtl/snake_body_buffer.sv
// Snake body store: up to MAX_LEN (x,y) segments with the newest head at index 0.
// Provides queued growth, sticky self-collision, a registered occupancy query and a renderer read port.
module snake_body_buffer #(
    parameter int COORD_W  = 4,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    localparam int LEN_W   = $clog2(MAX_LEN + 1),
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               step,
    input  logic [COORD_W-1:0] head_x,
    input  logic [COORD_W-1:0] head_y,
    input  logic               grow,
    output logic [LEN_W-1:0]   len_out,
    output logic               full,
    output logic               self_hit,
    input  logic [COORD_W-1:0] q_x,
    input  logic [COORD_W-1:0] q_y,
    output logic               q_hit,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_vld
);

    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   grow_cnt;

    logic               do_grow;
    logic [LEN_W-1:0]   new_len;
    logic [LEN_W-1:0]   grow_cnt_nxt;
    logic               head_hit;
    logic               query_hit;
    logic [COORD_W-1:0] rd_x_nxt;
    logic [COORD_W-1:0] rd_y_nxt;
    logic               rd_vld_nxt;

    assign len_out = len;
    assign full    = (len == LEN_MAX);

    always_comb begin
        do_grow      = ((grow_cnt != '0) || grow) && (len < LEN_MAX);
        new_len      = do_grow ? (len + LEN_ONE) : len;
        grow_cnt_nxt = grow_cnt;
        head_hit     = 1'b0;
        query_hit    = 1'b0;
        rd_x_nxt     = '0;
        rd_y_nxt     = '0;
        rd_vld_nxt   = (LEN_W'(rd_idx) < len);

        // A grow coincident with a consuming step cancels out; otherwise grows queue up.
        if (step && do_grow) begin
            if (!grow) begin
                grow_cnt_nxt = grow_cnt - LEN_ONE;
            end
        end else if (grow && (grow_cnt != LEN_MAX)) begin
            grow_cnt_nxt = grow_cnt + LEN_ONE;
        end

        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len) begin
                if ((seg_x[i] == q_x) && (seg_y[i] == q_y)) begin
                    query_hit = 1'b1;
                end
                // The tail cell is vacated by a non-growing step, so it cannot be hit.
                if ((seg_x[i] == head_x) && (seg_y[i] == head_y) &&
                    ((LEN_W'(i) != (len - LEN_ONE)) || do_grow)) begin
                    head_hit = 1'b1;
                end
            end
        end

        if (int'(rd_idx) < MAX_LEN) begin
            rd_x_nxt = seg_x[rd_idx];
            rd_y_nxt = seg_y[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= '0;
                seg_y[i] <= '0;
            end
            len      <= LEN_INIT;
            grow_cnt <= '0;
            self_hit <= 1'b0;
            q_hit    <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
            rd_vld   <= 1'b0;
        end else begin
            grow_cnt <= grow_cnt_nxt;
            q_hit    <= query_hit;
            rd_x     <= rd_x_nxt;
            rd_y     <= rd_y_nxt;
            rd_vld   <= rd_vld_nxt;
            if (step) begin
                len <= new_len;
                if (head_hit) begin
                    self_hit <= 1'b1;
                end
                seg_x[0] <= head_x;
                seg_y[0] <= head_y;
                // Slots beyond the new length are cleared so unused entries always read 0.
                for (int i = 1; i < MAX_LEN; i++) begin
                    if (LEN_W'(i) >= new_len) begin
                        seg_x[i] <= '0;
                        seg_y[i] <= '0;
                    end else begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_snake_body_buffer.sv
// Scoreboard bench for snake_body_buffer: a queue-based body model predicts every registered output,
// and a separate monitor compares one prediction per clock edge.
module tb_snake_body_buffer;

    localparam int COORD_W  = 4;
    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 4;
    localparam int LEN_W    = $clog2(MAX_LEN + 1);
    localparam int IDX_W    = $clog2(MAX_LEN);

    logic               clk;
    logic               rst;
    logic               clear;
    logic               step;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic               grow;
    logic [LEN_W-1:0]   len_out;
    logic               full;
    logic               self_hit;
    logic [COORD_W-1:0] q_x;
    logic [COORD_W-1:0] q_y;
    logic               q_hit;
    logic [IDX_W-1:0]   rd_idx;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;
    logic               rd_vld;

    snake_body_buffer #(
        .COORD_W (COORD_W),
        .MAX_LEN (MAX_LEN),
        .INIT_LEN(INIT_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .step    (step),
        .head_x  (head_x),
        .head_y  (head_y),
        .grow    (grow),
        .len_out (len_out),
        .full    (full),
        .self_hit(self_hit),
        .q_x     (q_x),
        .q_y     (q_y),
        .q_hit   (q_hit),
        .rd_idx  (rd_idx),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .rd_vld  (rd_vld)
    );

    typedef struct {
        int len;
        bit full;
        bit self_hit;
        bit q_hit;
        bit rd_vld;
        int rd_x;
        int rd_y;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: body as a list of cells, head first, list size is the length.
    int body_x[$];
    int body_y[$];
    int pend;
    bit m_hit;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    task automatic model_reset();
        body_x.delete();
        body_y.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            body_x.push_back(0);
            body_y.push_back(0);
        end
        pend  = 0;
        m_hit = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit s_rst, input bit s_clear, input bit s_step, input bit s_grow,
                                 input int hx, input int hy, input int qx, input int qy, input int idx);
        exp_t e;
        bit   g;
        int   len;
        int   span;
        bit   hit;
        @(negedge clk);
        rst    = s_rst;
        clear  = s_clear;
        step   = s_step;
        grow   = s_grow;
        head_x = COORD_W'(hx);
        head_y = COORD_W'(hy);
        q_x    = COORD_W'(qx);
        q_y    = COORD_W'(qy);
        rd_idx = IDX_W'(idx);

        len     = body_x.size();
        e.q_hit = 1'b0;
        for (int i = 0; i < len; i++)
            if (body_x[i] == qx && body_y[i] == qy) e.q_hit = 1'b1;
        e.rd_vld = (idx < len);
        e.rd_x   = e.rd_vld ? body_x[idx] : 0;
        e.rd_y   = e.rd_vld ? body_y[idx] : 0;

        if (s_rst || s_clear) begin
            model_reset();
            e.q_hit  = 1'b0;
            e.rd_vld = 1'b0;
            e.rd_x   = 0;
            e.rd_y   = 0;
        end else begin
            g = ((pend > 0) || s_grow) && (len < MAX_LEN);
            if (s_step) begin
                span = g ? len : len - 1;
                hit  = 1'b0;
                for (int i = 0; i < span; i++)
                    if (body_x[i] == hx && body_y[i] == hy) hit = 1'b1;
                if (hit) m_hit = 1'b1;
                body_x.push_front(hx);
                body_y.push_front(hy);
                if (!g) begin
                    void'(body_x.pop_back());
                    void'(body_y.pop_back());
                end
            end
            if (s_step && g) begin
                if (!s_grow) pend--;
            end else if (s_grow && pend < MAX_LEN) begin
                pend++;
            end
        end
        e.len      = body_x.size();
        e.full     = (e.len == MAX_LEN);
        e.self_hit = m_hit;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int qx, input int qy, input int idx);
        applyStimulus(0, 0, 0, 0, 0, 0, qx, qy, idx);
    endtask

    task automatic do_step(input int hx, input int hy, input bit g);
        applyStimulus(0, 0, 1, g, hx, hy, 0, 0, 0);
    endtask

    // Monitor: one registered response per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("len_out", int'(len_out), e.len);
                checkOutput("full", int'(full), int'(e.full));
                checkOutput("self_hit", int'(self_hit), int'(e.self_hit));
                checkOutput("q_hit", int'(q_hit), int'(e.q_hit));
                checkOutput("rd_vld", int'(rd_vld), int'(e.rd_vld));
                checkOutput("rd_x", int'(rd_x), e.rd_x);
                checkOutput("rd_y", int'(rd_y), e.rd_y);
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0; step = 1'b0; grow = 1'b0;
        head_x = '0; head_y = '0; q_x = '0; q_y = '0; rd_idx = '0;
        model_reset();

        // Basic shift and readback
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) do_step(i, 0, 0);
        for (int i = 0; i <= 4; i++) idle(0, 0, i);

        // Queued growth, then growth coincident with a step
        idle(0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 5; i <= 7; i++) do_step(i, 1, 0);
        do_step(8, 1, 1);
        do_step(9, 1, 0);
        for (int i = 0; i < MAX_LEN; i++) idle(0, 0, i);

        // Saturation at MAX_LEN
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) do_step(i % 16, 3 + i / 16, 1);
        for (int i = 0; i < MAX_LEN; i++) idle(0, 0, i);

        // Tail exclusion: no hit without growth
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_step(1, 2, 0); do_step(1, 1, 0); do_step(2, 1, 0); do_step(2, 2, 0);
        do_step(1, 2, 0);
        idle(1, 2, 0);
        // Same move with growth collides and stays sticky
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        do_step(1, 2, 0); do_step(1, 1, 0); do_step(2, 1, 0); do_step(2, 2, 0);
        do_step(1, 2, 1);
        do_step(7, 7, 0); do_step(8, 7, 0);
        idle(0, 0, 0);

        // clear beats step and grow; pending growth is discarded
        applyStimulus(0, 1, 1, 1, 5, 5, 0, 0, 0);
        do_step(9, 9, 0);
        for (int i = 0; i < 6; i++) idle(0, 0, i);
        for (int i = 0; i < 6; i++) do_step(i, 6, i % 2);
        applyStimulus(1, 0, 1, 1, 3, 3, 0, 0, 0);
        do_step(4, 4, 0);
        for (int i = 0; i < 6; i++) idle(0, 0, i);

        // Query timing around a step
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) do_step(i, 0, 0);
        applyStimulus(0, 0, 1, 0, 5, 0, 3, 0, 3);
        idle(1, 0, 3);
        idle(5, 0, 0);

        // Randomised game play on a small board so collisions occur
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, MAX_LEN - 1)));
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending responses, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
